// File: rtl/pb_onepulse.sv
// Push-button conditioner: two-flop synchronizer, debounce filter and a press FSM
// that emits one pulse per accepted press plus one long_pulse when held long enough.
module pb_onepulse #(
    parameter int DEB_CYCLES  = 4,
    parameter int LONG_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in,
    output logic pulse,
    output logic long_pulse,
    output logic pb_level
);

    localparam int DW = $clog2(DEB_CYCLES) + 1;
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    logic [1:0]    sync_reg;
    logic          pb_sync;
    logic          level_reg, level_next;
    logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [1:0]    state_reg, state_next;
    logic          pulse_reg, pulse_next;
    logic          long_reg, long_next;
    logic          rise_evt, fall_evt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= pb_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign pb_sync = sync_reg[1];

    // Any disagreement that does not last DEB_CYCLES edges restarts the count.
    always_comb begin
        level_next   = level_reg;
        deb_cnt_next = '0;
        if (pb_sync != level_reg) begin
            if (deb_cnt_reg == DEB_MAX) level_next   = ~level_reg;
            else                        deb_cnt_next = deb_cnt_reg + 1'b1;
        end
    end

    // The FSM reacts to the debounced edge on the same clock that updates pb_level.
    assign rise_evt = ~level_reg &  level_next;
    assign fall_evt =  level_reg & ~level_next;

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        pulse_next    = 1'b0;
        long_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rise_evt) begin
                    state_next    = ST_HELD;
                    pulse_next    = 1'b1;
                    hold_cnt_next = '0;
                end
            end
            ST_HELD: begin
                hold_cnt_next = hold_cnt_reg + 1'b1;
                if (fall_evt) begin
                    state_next = ST_IDLE;
                end else if (hold_cnt_reg == LONG_MAX) begin
                    state_next = ST_LONG;
                    long_next  = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall_evt) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg    <= 1'b0;
            deb_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            state_reg    <= ST_IDLE;
            pulse_reg    <= 1'b0;
            long_reg     <= 1'b0;
        end else begin
            level_reg    <= level_next;
            deb_cnt_reg  <= deb_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            state_reg    <= state_next;
            pulse_reg    <= pulse_next;
            long_reg     <= long_next;
        end
    end

    assign pb_level   = level_reg;
    assign pulse      = pulse_reg;
    assign long_pulse = long_reg;

endmodule

// File: tb/tb_pb_onepulse.sv
// Directed bench for pb_onepulse (DEB_CYCLES=4, LONG_CYCLES=10) with immediate
// assertions at each check point and a small mode-toggle model fed by pulse.
`timescale 1ns/1ps
module tb_pb_onepulse;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pb_in = 1'b0;
    logic pulse, long_pulse, pb_level;
    logic mode;

    int n_total = 0;
    int n_pass  = 0;

    pb_onepulse #(.DEB_CYCLES(4), .LONG_CYCLES(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb_in     (pb_in),
        .pulse     (pulse),
        .long_pulse(long_pulse),
        .pb_level  (pb_level)
    );

    always #5 clk = ~clk;

    // Start/pause mode FSM: toggles once per pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     mode <= 1'b0;
        else if (pulse) mode <= ~mode;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk3(input string tag, input int i, input logic ep, input logic el, input logic ev);
        chk($sformatf("%s[%0d].pulse", tag, i), pulse, ep);
        chk($sformatf("%s[%0d].long_pulse", tag, i), long_pulse, el);
        chk($sformatf("%s[%0d].pb_level", tag, i), pb_level, ev);
    endtask

    // Clean press: hi cycles high then lo cycles low; accepted presses rise at edge 6
    // and fall 6 edges after pb_in drops.
    task automatic press_window(input string tag, input int hi, input int lo,
                                input int pulse_at, input int long_at);
        for (int i = 1; i <= hi + lo; i++) begin
            pb_in = (i <= hi);
            tick();
            chk3(tag, i, (i == pulse_at), (i == long_at), (i >= 6 && i < hi + 6));
        end
        $display("step %s: hi=%0d lo=%0d done", tag, hi, lo);
    endtask

    logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset state
        rst_n = 1'b0;
        pb_in = 1'b0;
        tick(); tick(); tick();
        chk3("reset", 0, 1'b0, 1'b0, 1'b0);
        chk("reset.mode", mode, 1'b0);
        rst_n = 1'b1;
        tick();
        $display("step reset: released");

        // 1: 8-cycle press
        press_window("press8", 8, 10, 6, 0);

        // 2: bouncing press, pb_sync's final stable run begins at edge 7
        for (int i = 1; i <= 14; i++) begin
            pb_in = (i <= 9) ? pat[i-1] : 1'b1;
            tick();
            chk3("bounce", i, (i == 11), 1'b0, (i >= 11));
        end
        for (int i = 1; i <= 10; i++) begin
            pb_in = 1'b0;
            tick();
            chk3("bounce_rel", i, 1'b0, 1'b0, (i < 6));
        end
        $display("step bounce: done");

        // Short high glitch is rejected
        for (int i = 1; i <= 11; i++) begin
            pb_in = (i <= 3);
            tick();
            chk3("glitch_hi", i, 1'b0, 1'b0, 1'b0);
        end
        $display("step glitch_hi: done");

        // Short low glitch while held is rejected; long press still fires at 16
        for (int i = 1; i <= 21; i++) begin
            pb_in = !(i >= 10 && i <= 12);
            tick();
            chk3("glitch_lo", i, (i == 6), (i == 16), (i >= 6));
        end
        for (int i = 1; i <= 10; i++) begin
            pb_in = 1'b0;
            tick();
            chk3("glitch_lo_rel", i, 1'b0, 1'b0, (i < 6));
        end
        $display("step glitch_lo: done");

        // 3: 40-cycle hold
        press_window("hold40", 40, 10, 6, 16);

        // 4: fall coincides with hold_cnt==9, then the FSM must accept a new press
        press_window("fall_vs_long", 10, 10, 6, 0);
        press_window("after_fall", 8, 10, 6, 0);

        // 5a: reset during the pulse cycle
        for (int i = 1; i <= 6; i++) begin
            pb_in = 1'b1;
            tick();
            chk3("rst_pulse_pre", i, (i == 6), 1'b0, (i >= 6));
        end
        rst_n = 1'b0;
        #1;
        chk3("rst_pulse_now", 0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk3("rst_pulse_post", i, (i == 6), 1'b0, (i >= 6));
        end
        for (int i = 1; i <= 10; i++) begin
            pb_in = 1'b0;
            tick();
            chk3("rst_pulse_rel", i, 1'b0, 1'b0, (i < 6));
        end
        $display("step reset_mid_pulse: done");

        // 5b: reset mid-debounce
        for (int i = 1; i <= 4; i++) begin
            pb_in = 1'b1;
            tick();
            chk3("rst_deb_pre", i, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk3("rst_deb_now", 0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk3("rst_deb_post", i, (i == 6), 1'b0, (i >= 6));
        end
        for (int i = 1; i <= 10; i++) begin
            pb_in = 1'b0;
            tick();
            chk3("rst_deb_rel", i, 1'b0, 1'b0, (i < 6));
        end
        $display("step reset_mid_debounce: done");

        // 6: mode FSM sequence 0 -> 1 -> 0 -> 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mode0", mode, 1'b0);
        press_window("mode_p1", 8, 10, 6, 0);
        chk("mode1", mode, 1'b1);
        press_window("mode_p2", 8, 10, 6, 0);
        chk("mode2", mode, 1'b0);
        press_window("mode_p3", 8, 10, 6, 0);
        chk("mode3", mode, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pb_onepulse.md
# pb_onepulse

Push-button conditioner that generates the `pulse` input consumed by the start/pause mode FSM (and any other toggle FSM in the lab designs). It synchronizes a raw, bouncing button into the clock domain, debounces it, and emits exactly one single-cycle `pulse` per physical press. It also emits a separate one-cycle `long_pulse` when the button is held past a threshold, for use as a clear/reset request. Release never generates a pulse.

## Interface

- `DEB_CYCLES`, default 4: consecutive stable cycles required to accept a level change. Legal range is 1..2^16.
- `LONG_CYCLES`, default 10: cycles after `pulse` before `long_pulse` fires while still held. Legal range is 1..2^24.
- `clk`  input  1  system clock; all state updates on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `pb_in`  input  1  raw push-button level, asynchronous to `clk`, active-high, may bounce.
- `pulse`  output  1  registered; high for exactly one cycle per accepted press.
- `long_pulse`  output  1  registered; high for exactly one cycle per press held ≥ `LONG_CYCLES`.
- `pb_level`  output  1  registered debounced button level.

## Operation

**Synchronizer**
- Two-flop chain: `pb_in` → `s1` → `pb_sync`. Both flops reset to 0.

**Debounce**
- Counter `deb_cnt` is `$clog2(DEB_CYCLES)+1` bits wide and resets to 0.
- On each edge where `pb_sync != pb_level`:
  - if `deb_cnt == DEB_CYCLES-1`, toggle `pb_level` and clear `deb_cnt`;
  - otherwise increment `deb_cnt`.
- On any edge where `pb_sync == pb_level`, clear `deb_cnt`. A bounce therefore restarts the count.

**Press FSM** (3 states, reset to IDLE)
- IDLE, where `pb_level` = 0:
  - On the edge where `pb_level` rises, go to HELD, assert `pulse`, and clear `hold_cnt`.
- HELD:
  - Each edge, increment `hold_cnt`.
  - If `hold_cnt == LONG_CYCLES-1`, assert `long_pulse` and go to LONG.
  - If `pb_level` falls, go to IDLE with no output. The fall takes priority over the long-press check on the same edge.
- LONG:
  - Stay here until `pb_level` falls, then go to IDLE.
  - No further pulses are generated in this state.

**Counters and outputs**
- `hold_cnt` is `$clog2(LONG_CYCLES)+1` bits wide. It only counts in HELD, so it never wraps.
- `pulse` and `long_pulse` are never high in the same cycle.
- Both are registered and default to 0 every cycle unless set as above.

## Timing

- Reset values: `s1`, `pb_sync`, `pb_level`, `pulse`, `long_pulse`, `deb_cnt` and `hold_cnt` are all 0. State is IDLE.
- Press latency: with `pb_in` stable high before edge 1, `pb_level` and `pulse` go high after edge `2+DEB_CYCLES`. For `DEB_CYCLES`=4 this is after edge 6.
- Long-press latency: `long_pulse` goes high `LONG_CYCLES` edges after the edge that raised `pulse`.
- Release latency: `pb_level` falls `2+DEB_CYCLES` edges after `pb_in` falls and stays low.
- Glitches: a high or low excursion of `pb_sync` lasting fewer than `DEB_CYCLES` cycles has no effect on any output.
- Button held at reset release: if `pb_in` is high when `rst_n` deasserts, the press is accepted normally after `2+DEB_CYCLES` edges and one `pulse` is produced.
- Reset mid-operation: asserting `rst_n` low clears all outputs immediately, including mid-`pulse` and mid-debounce. No pulse is pending after reset.
- Continuous hold: exactly one `pulse` and one `long_pulse` per press, regardless of hold duration.

## Test plan

Parameters for all scenarios: `DEB_CYCLES`=4, `LONG_CYCLES`=10.

1. Reset, then `pb_in`=1 held for 8 cycles, then 0 → `pulse` high for one cycle only, after edge 6. `long_pulse` stays 0. `pb_level` returns to 0 six edges after `pb_in` falls.
2. Bounce `pb_in` with pattern 1,0,1,1,0,1,1,1,1 (one value per cycle) → exactly one `pulse`, raised 4 edges after the final stable run begins at `pb_sync`. Pulses of 1–3 cycles alone produce nothing.
3. Hold `pb_in`=1 for 40 cycles → `pulse` after edge 6, `long_pulse` after edge 16, then no further pulses. On release, no pulse is produced.
4. Release at `hold_cnt`=9 so that the `pb_level` fall coincides with the long-press threshold → `long_pulse` stays 0 and the FSM returns to IDLE.
5. Assert `rst_n` low during the `pulse` cycle and mid-debounce → outputs are 0 immediately. After release with `pb_in`=1, one new `pulse` arrives after 6 edges.
6. Connect `pulse` to the mode FSM and perform three clean presses → mode sequence is 0→1→0→1, with one toggle per press.
